// File: rtl/alu_pkg.sv
// Shared definitions for the ALU register sequencer: opcodes, FSM encoding, data width.
package alu_pkg;

  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_OR  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_e;

endpackage

// File: rtl/alu_reg_sequencer_if.sv
// Instruction handshake bundle between an instruction source (master) and the sequencer (slave).
interface alu_reg_sequencer_if #(
  parameter int unsigned AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [AW-1:0] in_rd;
  logic [AW-1:0] in_rs1;
  logic [AW-1:0] in_rs2;

  modport master (output in_valid, in_op, in_rd, in_rs1, in_rs2, input in_ready);
  modport slave  (input in_valid, in_op, in_rd, in_rs1, in_rs2, output in_ready);
endinterface

// File: rtl/reg_file_2r1w.sv
// Register file: two combinational read ports, one synchronous write port, R0 reads as zero.
module reg_file_2r1w
  import alu_pkg::*;
#(
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     raddr_a,
  output logic [DATA_W-1:0] rdata_a_c,
  input  logic [AW-1:0]     raddr_b,
  output logic [DATA_W-1:0] rdata_b_c,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Entry 0 is forced to zero so reads of R0 need no special case.
  always_comb begin
    regs_d = regs_q;
    if (we && (waddr != '0)) regs_d[waddr] = wdata;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rdata_a_c = regs_q[raddr_a];
  assign rdata_b_c = regs_q[raddr_b];

endmodule

// File: rtl/alu_reg_sequencer.sv
// Sequencer feeding an external 16-bit ALU from a register file and writing results back.
// Optional carry flag enabled by macro ALU_SEQ_CARRY_FLAG_EN.
module alu_reg_sequencer
  import alu_pkg::*;
#(
  parameter  int unsigned NREGS = 8,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  alu_reg_sequencer_if.slave   in_if,
  input  logic                 ld_en,
  input  logic [AW-1:0]        ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  input  logic [AW-1:0]        dbg_addr,
  output logic [DATA_W-1:0]    dbg_data,
  output logic [1:0]           alu_op,
  output logic [DATA_W-1:0]    alu_a,
  output logic [DATA_W-1:0]    alu_b,
  input  logic [DATA_W-1:0]    alu_o,
  input  logic                 alu_cout,
  output logic                 done,
  output logic                 carry
);

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [AW-1:0]     rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [1:0]        alu_op_q, alu_op_d;
  logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              cout_q, cout_d;
  logic              done_q, done_d;
  logic              in_ready_q, in_ready_d;

  logic [AW-1:0]     raddr_a, waddr;
  logic [DATA_W-1:0] rdata_a, rdata_b, wdata;
  logic              we;

  // Port A serves the debug read except while operands are being fetched.
  assign raddr_a = (state_q == ST_READ) ? rs1_q : dbg_addr;
  assign dbg_data = rdata_a;

  // Loads and write-backs occupy different states, so one write port suffices.
  always_comb begin
    we    = 1'b0;
    waddr = ld_addr;
    wdata = ld_data;
    if (state_q == ST_IDLE) begin
      we = ld_en && (ld_addr != '0);
    end else if (state_q == ST_WB) begin
      we    = (rd_q != '0);
      waddr = rd_q;
      wdata = res_q;
    end
  end

  reg_file_2r1w #(.NREGS(NREGS)) u_rf (
    .clk       (clk),
    .rst_n     (rst_n),
    .raddr_a   (raddr_a),
    .rdata_a_c (rdata_a),
    .raddr_b   (rs2_q),
    .rdata_b_c (rdata_b),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata)
  );

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    alu_op_d = alu_op_q;
    alu_a_d  = alu_a_q;
    alu_b_d  = alu_b_q;
    res_d    = res_q;
    cout_d   = cout_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_if.in_valid) begin
          op_d    = in_if.in_op;
          rd_d    = in_if.in_rd;
          rs1_d   = in_if.in_rs1;
          rs2_d   = in_if.in_rs2;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        alu_a_d  = rdata_a;
        alu_b_d  = rdata_b;
        alu_op_d = op_q;
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        res_d   = alu_o;
        cout_d  = alu_cout;
        done_d  = 1'b1;
        state_d = ST_WB;
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      res_q      <= res_d;
      cout_q     <= cout_d;
      done_q     <= done_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef ALU_SEQ_CARRY_FLAG_EN
  logic carry_q, carry_d;

  // Only arithmetic ops update the flag; logic ops leave it untouched.
  always_comb begin
    carry_d = carry_q;
    if ((state_q == ST_WB) && ((op_q == OP_ADD) || (op_q == OP_SUB))) carry_d = cout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

  assign carry = carry_q;
`else
  logic unused_cout;
  assign unused_cout = cout_q;
  assign carry       = 1'b0;
`endif

  assign in_if.in_ready = in_ready_q;
  assign alu_op         = alu_op_q;
  assign alu_a          = alu_a_q;
  assign alu_b          = alu_b_q;
  assign done           = done_q;

endmodule

// File: tb/tb_alu_reg_sequencer.sv
// Directed bench for alu_reg_sequencer with a behavioural ALU and a result scoreboard.
module tb_alu_reg_sequencer;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_data;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b, alu_o;
  logic        alu_cout, done, carry;

  alu_reg_sequencer_if #(.AW(3)) in_if ();

  alu_reg_sequencer #(.NREGS(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_if(in_if),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_o(alu_o), .alu_cout(alu_cout), .done(done), .carry(carry)
  );

  always #5 clk = ~clk;

  // Combinational ALU driven from the sequencer outputs.
  logic [16:0] alu_full;
  always_comb begin
    case (alu_op)
      OP_ADD:  alu_full = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB:  alu_full = {1'b0, alu_a} + {1'b0, ~alu_b} + 17'd1;
      OP_AND:  alu_full = {1'b0, alu_a & alu_b};
      default: alu_full = {1'b0, alu_a | alu_b};
    endcase
  end
  assign alu_o    = alu_full[15:0];
  assign alu_cout = alu_full[16];

  typedef struct {
    logic [2:0]  rd;
    logic [15:0] val;
    logic        c;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mregs [8];
  logic        exp_carry = 1'b0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] v);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = v;
    if (a != 3'd0) mregs[a] = v;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // ld_mode: 0 none, 1 load in the handshake cycle, 2 load attempt during EXEC.
  task automatic issue(input logic [1:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                       input logic [2:0] rs2, input int ld_mode, input logic [2:0] la,
                       input logic [15:0] lv);
    exp_t        e;
    logic [16:0] r;
    logic [15:0] a, b;
    int          cyc;
    @(negedge clk);
    in_if.in_valid = 1'b1; in_if.in_op = op;
    in_if.in_rd = rd; in_if.in_rs1 = rs1; in_if.in_rs2 = rs2;
    if (ld_mode == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    cyc = 0;
    while (!in_if.in_ready && cyc < 20) begin @(negedge clk); cyc++; end
    chk("hs_ready", {15'd0, in_if.in_ready}, 16'd1);
    if (ld_mode == 1 && la != 3'd0) mregs[la] = lv;
    a = mregs[rs1]; b = mregs[rs2];
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {1'b0, a} + {1'b0, ~b} + 17'd1;
      OP_AND:  r = {1'b0, a & b};
      default: r = {1'b0, a | b};
    endcase
    if (rd != 3'd0) mregs[rd] = r[15:0];
`ifdef ALU_SEQ_CARRY_FLAG_EN
    if (op == OP_ADD || op == OP_SUB) exp_carry = r[16];
`endif
    e.rd = rd; e.val = mregs[rd]; e.c = exp_carry;
    sb.push_back(e);
    @(negedge clk);  // READ
    in_if.in_valid = 1'b0; ld_en = 1'b0;
    chk("read_done", {15'd0, done}, 16'd0);
    chk("read_ready", {15'd0, in_if.in_ready}, 16'd0);
    @(negedge clk);  // EXEC
    chk("exec_done", {15'd0, done}, 16'd0);
    if (ld_mode == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = lv; end
    @(negedge clk);  // WB
    ld_en = 1'b0;
    chk("wb_done", {15'd0, done}, 16'd1);
    chk("wb_ready", {15'd0, in_if.in_ready}, 16'd0);
    e = sb.pop_front();
    dbg_addr = e.rd;
    @(negedge clk);  // back in IDLE
    chk("idle_done", {15'd0, done}, 16'd0);
    chk("idle_ready", {15'd0, in_if.in_ready}, 16'd1);
    chk("result", dbg_data, e.val);
    chk("carry", {15'd0, carry}, {15'd0, e.c});
  endtask

  initial begin
    int hs, last, gap_bad, cyc;
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    in_if.in_valid = 1'b0; in_if.in_op = '0;
    in_if.in_rd = '0; in_if.in_rs1 = '0; in_if.in_rs2 = '0;
    #12;
    chk("rst_ready", {15'd0, in_if.in_ready}, 16'd1);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_carry", {15'd0, carry}, 16'd0);
    chk("rst_alu_a", alu_a, 16'd0);
    chk("rst_alu_op", {14'd0, alu_op}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    load(3'd1, 16'h0005);
    load(3'd2, 16'h0003);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 0, 3'd0, 16'h0);
    issue(OP_SUB, 3'd4, 3'd2, 3'd1, 0, 3'd0, 16'h0);
    issue(OP_SUB, 3'd5, 3'd1, 3'd2, 0, 3'd0, 16'h0);
    load(3'd1, 16'hFFFF);
    issue(OP_ADD, 3'd1, 3'd1, 3'd1, 0, 3'd0, 16'h0);
    load(3'd2, 16'h0F0F);
    issue(OP_AND, 3'd6, 3'd1, 3'd2, 0, 3'd0, 16'h0);

    // Continuous offer: only one handshake per four cycles.
    @(negedge clk);
    in_if.in_valid = 1'b1; in_if.in_op = OP_AND;
    in_if.in_rd = 3'd6; in_if.in_rs1 = 3'd6; in_if.in_rs2 = 3'd6;
    hs = 0; last = -4; gap_bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (in_if.in_ready) begin
        if (i - last != 4) gap_bad++;
        last = i; hs++;
      end
      @(negedge clk);
    end
    in_if.in_valid = 1'b0;
    chk("tput_handshakes", 16'(hs), 16'd3);
    chk("tput_gap", 16'(gap_bad), 16'd0);
    cyc = 0;
    while (!in_if.in_ready && cyc < 10) begin @(negedge clk); cyc++; end
    dbg_addr = 3'd6;
    #1 chk("tput_r6", dbg_data, mregs[6]);

    issue(OP_OR, 3'd0, 3'd1, 3'd2, 2, 3'd2, 16'hAAAA);
    dbg_addr = 3'd2;
    #1 chk("exec_ld_ignored", dbg_data, 16'h0F0F);
    issue(OP_OR, 3'd7, 3'd7, 3'd0, 1, 3'd7, 16'h1234);

    // Asynchronous reset while an instruction is in EXEC.
    @(negedge clk);
    in_if.in_valid = 1'b1; in_if.in_op = OP_ADD;
    in_if.in_rd = 3'd3; in_if.in_rs1 = 3'd1; in_if.in_rs2 = 3'd1;
    @(negedge clk);
    in_if.in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_alu_a", alu_a, 16'hFFFE);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_alu_a", alu_a, 16'd0);
    chk("mid_rst_alu_b", alu_b, 16'd0);
    chk("mid_rst_alu_op", {14'd0, alu_op}, 16'd0);
    chk("mid_rst_done", {15'd0, done}, 16'd0);
    chk("mid_rst_carry", {15'd0, carry}, 16'd0);
    chk("mid_rst_ready", {15'd0, in_if.in_ready}, 16'd1);
    for (int i = 1; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1 chk("mid_rst_reg", dbg_data, 16'd0);
    end
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    exp_carry = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", {15'd0, done}, 16'd0);
      chk("post_rst_ready", {15'd0, in_if.in_ready}, 16'd1);
    end
    load(3'd1, 16'h0002);
    issue(OP_ADD, 3'd2, 3'd1, 3'd1, 0, 3'd0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
